// File: rtl/exp_lut_arbiter.sv
// rtl/exp_lut_arbiter.sv - round-robin arbiter sharing one e^n integer-part LUT
//
// Purpose: serialises exponent lookups from NUM_REQ requesters onto a single
// table. Each requester gets e^n in 14.18 unsigned fixed point. Each result is
// tagged with the requester index.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   req_valid  - [NUM_REQ] per-requester request valid
//   req_int    - [NUM_REQ*6] per-requester signed exponent, requester i at [6i+5:6i]
//   req_ready  - [NUM_REQ] one-hot grant, combinational, only in IDLE
//   resp_valid - result available
//   resp_ready - consumer accepts the result
//   resp_id    - [ID_W] requester index of the result
//   resp_exp   - [32] e^n, 14 integer bits / 18 fraction bits
//   resp_oor   - exponent was outside -5..9
//   busy       - FSM not in IDLE
//   lookup_cnt - [16] completed responses, saturating
//
// Build option: EXP_ARB_CLAMP_EN - when defined, negative out-of-range exponents
// return 0 and positive ones return 32'hFFFFFFFF. When undefined, every
// out-of-range exponent returns 32'hFFFFFFFF.

module exp_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*6-1:0] req_int,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_exp,
  output logic                 resp_oor,
  output logic                 busy,
  output logic [15:0]          lookup_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [5:0]      exp_in_q, exp_in_d;
  logic [31:0]     resp_exp_q, resp_exp_d;
  logic            resp_oor_q, resp_oor_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand;
  logic [ID_W:0]   grant_inc;
  logic [ID_W-1:0] rr_next;
  logic [32:0]     lut;

  // Table lookup: returns {oor, value}. Negative exponents appear as 6-bit
  // two's complement codes (-5 = 6'h3B ... -1 = 6'h3F).
  function automatic logic [32:0] exp_lookup(input logic [5:0] n);
    logic [32:0] r;
    case (n)
      6'h3B:   r = {1'b0, 32'd1766};
      6'h3C:   r = {1'b0, 32'd4801};
      6'h3D:   r = {1'b0, 32'd13051};
      6'h3E:   r = {1'b0, 32'd35477};
      6'h3F:   r = {1'b0, 32'd96437};
      6'h00:   r = {1'b0, 32'd262144};
      6'h01:   r = {1'b0, 32'd712581};
      6'h02:   r = {1'b0, 32'd1936997};
      6'h03:   r = {1'b0, 32'd5265303};
      6'h04:   r = {1'b0, 32'd14312577};
      6'h05:   r = {1'b0, 32'd38905619};
      6'h06:   r = {1'b0, 32'd105756438};
      6'h07:   r = {1'b0, 32'd287475803};
      6'h08:   r = {1'b0, 32'd781440251};
      6'h09:   r = {1'b0, 32'd2124174833};
`ifdef EXP_ARB_CLAMP_EN
      // The sign bit separates underflow (-32..-6) from overflow (10..31).
      default: r = n[5] ? {1'b1, 32'd0} : {1'b1, 32'hFFFF_FFFF};
`else
      default: r = {1'b1, 32'hFFFF_FFFF};
`endif
    endcase
    return r;
  endfunction

  assign lut = exp_lookup(exp_in_q);

  // Round-robin search. It starts at rr_ptr_q, wraps modulo NUM_REQ, and the
  // first valid requester wins.
  always_comb begin : rr_search
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign grant_inc = {1'b0, grant_idx} + (ID_W+1)'(1);
  assign rr_next   = (grant_inc == (ID_W+1)'(NUM_REQ)) ? '0 : grant_inc[ID_W-1:0];

  always_comb begin : fsm_next
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    exp_in_d   = exp_in_q;
    resp_exp_d = resp_exp_q;
    resp_oor_d = resp_oor_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          exp_in_d             = req_int[6*grant_idx +: 6];
          id_d                 = grant_idx;
          rr_ptr_d             = rr_next;
          state_d              = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        resp_exp_d = lut[31:0];
        resp_oor_d = lut[32];
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      exp_in_q   <= '0;
      resp_exp_q <= '0;
      resp_oor_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      exp_in_q   <= exp_in_d;
      resp_exp_q <= resp_exp_d;
      resp_oor_q <= resp_oor_d;
      cnt_q      <= cnt_d;
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_id    = id_q;
  assign resp_exp   = resp_exp_q;
  assign resp_oor   = resp_oor_q;
  assign lookup_cnt = cnt_q;

endmodule
